// File: rtl/wb_stage_pipe.sv
// Write-back stage: selects and extends the write-back result, registers it toward the
// register file through a valid/ready handshake with a one-entry skid buffer, counts retirements.
module wb_stage_pipe #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWrite_in,
  input  logic [1:0]        ResultSrc_in,
  input  logic [1:0]        LoadMode_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] link_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              wb_ready,
  output logic              out_valid,
  output logic              RegWrite_final,
  output logic [DATA_W-1:0] write_data_WB,
  output logic [REG_AW-1:0] rd_final,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  retire_count
);

  localparam int unsigned PAY_W = 1 + REG_AW + DATA_W;

  logic [DATA_W-1:0] byte_zext_c;
  logic [DATA_W-1:0] byte_sext_c;
  logic [DATA_W-1:0] mem_ext_c;
  logic [DATA_W-1:0] result_c;
  logic              in_we_c;
  logic [PAY_W-1:0]  in_pay_c;

  logic              out_valid_q, out_valid_d;
  logic              out_we_q,    out_we_d;
  logic [REG_AW-1:0] out_rd_q,    out_rd_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              skid_full_q, skid_full_d;
  logic [PAY_W-1:0]  skid_pay_q,  skid_pay_d;
  logic              in_ready_q,  in_ready_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic              accept_c;
  logic              handoff_c;

  // Byte extension collapses to the full word when the datapath is only one byte wide
  if (DATA_W > 8) begin : g_ext_wide
    assign byte_zext_c = {{(DATA_W-8){1'b0}}, mem_data_in[7:0]};
    assign byte_sext_c = {{(DATA_W-8){mem_data_in[7]}}, mem_data_in[7:0]};
  end else begin : g_ext_byte
    assign byte_zext_c = mem_data_in;
    assign byte_sext_c = mem_data_in;
  end

  always_comb begin
    mem_ext_c = mem_data_in;
    case (LoadMode_in)
      2'b01:   mem_ext_c = byte_zext_c;
      2'b10:   mem_ext_c = byte_sext_c;
      default: mem_ext_c = mem_data_in;
    endcase
  end

  always_comb begin
    result_c = alu_result_in;
    case (ResultSrc_in)
      2'b01:   result_c = mem_ext_c;
      2'b10:   result_c = link_in;
      2'b11:   result_c = imm_in;
      default: result_c = alu_result_in;
    endcase
  end

  // Write enable is resolved at entry so the suppression travels with the instruction
  assign in_we_c   = RegWrite_in && !((ZERO_REG != 0) && (rd_in == '0));
  assign in_pay_c  = {in_we_c, rd_in, result_c};
  assign accept_c  = in_valid && in_ready_q;
  assign handoff_c = out_valid_q && wb_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_we_d    = out_we_q;
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;
    skid_full_d = skid_full_q;
    skid_pay_d  = skid_pay_q;
    cnt_d       = cnt_q;
    if (handoff_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (!out_valid_q || handoff_c) begin
      if (skid_full_q) begin
        {out_we_d, out_rd_d, out_data_d} = skid_pay_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
      end else if (accept_c) begin
        {out_we_d, out_rd_d, out_data_d} = in_pay_c;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        out_we_d    = 1'b0;
      end
    end else if (accept_c) begin
      skid_pay_d  = in_pay_c;
      skid_full_d = 1'b1;
    end
    in_ready_d = !skid_full_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_we_q    <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
      skid_full_q <= 1'b0;
      skid_pay_q  <= '0;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_we_q    <= out_we_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
      skid_full_q <= skid_full_d;
      skid_pay_q  <= skid_pay_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign RegWrite_final = out_we_q;
  assign fwd_valid      = out_we_q;
  assign write_data_WB  = out_data_q;
  assign rd_final       = out_rd_q;
  assign retire_count   = cnt_q;

endmodule
